// File: rtl/fft2_din_ctrl.sv
// fft2_din_ctrl
// Read sequencer for the 2D-FFT input buffer. Walks the FFT_SIZE x FFT_SIZE
// complex matrix in row-major (row pass) or column-major (column pass) order.
// It issues one read at a time to the input buffer and forwards each sample
// to the 1D FFT core over a valid/ready stream, flagging the last sample of
// every vector.
//
// Optional feature macro: FFT2_DIN_CTRL_BITREV_EN
//   defined   : element index is bit-reversed in the address (DIT core input)
//   undefined : natural element order
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   start_i, pass_col_i start pulse and pass order (0 row, 1 column)
//   busy_o, done_o      pass in progress / one-cycle end-of-pass pulse
//   data_i_addr_o       input-buffer read address {vector, element} or
//                       {element, vector}
//   data_rd_o/data_rd_i read request / acknowledge (data valid with ack)
//   dataRE_i, dataIM_i  read data
//   fft_re_o, fft_im_o  sample to FFT core
//   fft_valid_o/_ready_i stream handshake, fft_last_o marks end of vector
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for start_i
// S_READ | read request outstanding, address stable
// S_OUT  | sample presented to the FFT core, waiting for ready
// S_DONE | one-cycle end-of-pass pulse
module fft2_din_ctrl #(
   parameter int  DATA_WIDTH = 32,
   parameter int  FFT_SIZE   = 16,
   localparam int LOG2N      = $clog2(FFT_SIZE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  pass_col_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [2*LOG2N-1:0]    data_i_addr_o,
   output logic                  data_rd_o,
   input  logic                  data_rd_i,
   input  logic [DATA_WIDTH-1:0] dataRE_i,
   input  logic [DATA_WIDTH-1:0] dataIM_i,
   output logic [DATA_WIDTH-1:0] fft_re_o,
   output logic [DATA_WIDTH-1:0] fft_im_o,
   output logic                  fft_valid_o,
   output logic                  fft_last_o,
   input  logic                  fft_ready_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_OUT  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t                state_q, state_d;
   logic                  pass_col_q, pass_col_d;
   logic [LOG2N-1:0]      i_q, i_d;
   logic [LOG2N-1:0]      j_q, j_d;
   logic                  final_q, final_d;
   logic [2*LOG2N-1:0]    addr_q, addr_d;
   logic [DATA_WIDTH-1:0] re_q, re_d;
   logic [DATA_WIDTH-1:0] im_q, im_d;
   logic                  last_q, last_d;
   logic                  rd_q, rd_d;
   logic                  valid_q, valid_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   // Element index as it appears in the address.
   function automatic logic [LOG2N-1:0] order_j(input logic [LOG2N-1:0] j);
`ifdef FFT2_DIN_CTRL_BITREV_EN
      logic [LOG2N-1:0] r;
      for (int b = 0; b < LOG2N; b++) begin
         r[b] = j[LOG2N-1-b];
      end
      return r;
`else
      return j;
`endif
   endfunction

   always_comb begin
      state_d    = state_q;
      pass_col_d = pass_col_q;
      i_d        = i_q;
      j_d        = j_q;
      final_d    = final_q;
      addr_d     = addr_q;
      re_d       = re_q;
      im_d       = im_q;
      last_d     = last_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               pass_col_d = pass_col_i;
               i_d        = '0;
               j_d        = '0;
               final_d    = 1'b0;
               last_d     = 1'b0;
               addr_d     = '0;
               state_d    = S_READ;
            end
         end
         S_READ: begin
            if (data_rd_i) begin
               re_d    = dataRE_i;
               im_d    = dataIM_i;
               last_d  = (j_q == {LOG2N{1'b1}});
               final_d = last_d && (i_q == {LOG2N{1'b1}});
               j_d     = j_q + LOG2N'(1);
               if (last_d) begin
                  i_d = i_q + LOG2N'(1);
               end
               // Next address is prepared now so it is already stable when
               // the following read is issued.
               addr_d  = pass_col_q ? {order_j(j_d), i_d} : {i_d, order_j(j_d)};
               state_d = S_OUT;
            end
         end
         S_OUT: begin
            if (fft_ready_i) begin
               state_d = final_q ? S_DONE : S_READ;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Status outputs are registered copies of the next-state decode.
      rd_d    = (state_d == S_READ);
      valid_d = (state_d == S_OUT);
      busy_d  = (state_d != S_IDLE);
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         pass_col_q <= 1'b0;
         i_q        <= '0;
         j_q        <= '0;
         final_q    <= 1'b0;
         addr_q     <= '0;
         re_q       <= '0;
         im_q       <= '0;
         last_q     <= 1'b0;
         rd_q       <= 1'b0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pass_col_q <= pass_col_d;
         i_q        <= i_d;
         j_q        <= j_d;
         final_q    <= final_d;
         addr_q     <= addr_d;
         re_q       <= re_d;
         im_q       <= im_d;
         last_q     <= last_d;
         rd_q       <= rd_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign data_i_addr_o = addr_q;
   assign data_rd_o     = rd_q;
   assign fft_re_o      = re_q;
   assign fft_im_o      = im_q;
   assign fft_valid_o   = valid_q;
   assign fft_last_o    = last_q;

endmodule

// File: tb/tb_fft2_din_ctrl.sv
// Testbench for fft2_din_ctrl at FFT_SIZE=4, DATA_WIDTH=16.
module tb_fft2_din_ctrl;
   localparam int DW = 16;
   localparam int N  = 4;
   localparam int LG = 2;
   localparam int NN = N * N;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          pass_col_i;
   logic          busy_o;
   logic          done_o;
   logic [2*LG-1:0] data_i_addr_o;
   logic          data_rd_o;
   logic          data_rd_i;
   logic [DW-1:0] dataRE_i;
   logic [DW-1:0] dataIM_i;
   logic [DW-1:0] fft_re_o;
   logic [DW-1:0] fft_im_o;
   logic          fft_valid_o;
   logic          fft_last_o;
   logic          fft_ready_i;

   always #5 clk = ~clk;

   fft2_din_ctrl #(.DATA_WIDTH(DW), .FFT_SIZE(N)) dut (
      .clk           (clk),
      .rst           (rst),
      .start_i       (start_i),
      .pass_col_i    (pass_col_i),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .data_i_addr_o (data_i_addr_o),
      .data_rd_o     (data_rd_o),
      .data_rd_i     (data_rd_i),
      .dataRE_i      (dataRE_i),
      .dataIM_i      (dataIM_i),
      .fft_re_o      (fft_re_o),
      .fft_im_o      (fft_im_o),
      .fft_valid_o   (fft_valid_o),
      .fft_last_o    (fft_last_o),
      .fft_ready_i   (fft_ready_i)
   );

   typedef struct {
      logic pass_col;
      int   rd_wait_at;
      int   rd_wait_len;
      int   stall_at;
      int   stall_len;
      int   exp_done;
   } vec_t;

   vec_t tab[5];
   int   exp_row[NN];
   int   exp_col[NN];
   int   n_vec = 0;
   int   n_err = 0;

   function automatic logic [DW-1:0] f_re(input int a);
      return 16'hA500 + 16'(a * 17);
   endfunction

   function automatic logic [DW-1:0] f_im(input int a);
      return 16'h3C00 + 16'(a * 3);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  32'(busy_o), 0);
      check({tag, "_done"},  32'(done_o), 0);
      check({tag, "_rd"},    32'(data_rd_o), 0);
      check({tag, "_valid"}, 32'(fft_valid_o), 0);
      check({tag, "_last"},  32'(fft_last_o), 0);
      check({tag, "_addr"},  32'(data_i_addr_o), 0);
      check({tag, "_re"},    32'(fft_re_o), 0);
      check({tag, "_im"},    32'(fft_im_o), 0);
   endtask

   task automatic run_pass(input vec_t v);
      int order[NN];
      int cyc, rd_idx, out_idx, rd_cnt, st_cnt, done_cyc;
      logic fin;
      logic [2*LG-1:0] hold_addr;
      logic [DW-1:0] hold_re, hold_im;
      for (int k = 0; k < NN; k++) begin
         if (v.pass_col) order[k] = exp_col[k];
         else            order[k] = exp_row[k];
      end
      cyc = 0; rd_idx = 0; out_idx = 0; rd_cnt = 0; st_cnt = 0; done_cyc = -1;
      fin = 1'b0; hold_addr = '0; hold_re = '0; hold_im = '0;

      pass_col_i  = v.pass_col;
      start_i     = 1'b1;
      data_rd_i   = 1'b0;
      fft_ready_i = 1'b0;
      tick();
      cyc = 1;
      check("busy_after_start", 32'(busy_o), 1);
      check("rd_after_start", 32'(data_rd_o), 1);

      while (!fin && cyc < 300) begin
         start_i = 1'b0;
         if (cyc == 5) begin
            start_i    = 1'b1;
            pass_col_i = ~v.pass_col;
         end
         data_rd_i = 1'b1;
         dataRE_i  = 16'hDEAD;
         dataIM_i  = 16'hBEEF;

         // read side: optional wait states on one read
         if (rd_idx == v.rd_wait_at && rd_cnt > 0 && rd_cnt < v.rd_wait_len) begin
            data_rd_i = 1'b0;
            check("rd_held_in_wait", 32'(data_rd_o), 1);
            check("addr_held_in_wait", 32'(data_i_addr_o), 32'(hold_addr));
            rd_cnt++;
         end else if (data_rd_o) begin
            if (rd_idx == v.rd_wait_at && rd_cnt == 0 && v.rd_wait_len > 0) begin
               data_rd_i = 1'b0;
               hold_addr = data_i_addr_o;
               rd_cnt    = 1;
            end else begin
               if (rd_idx < NN) check("addr", 32'(data_i_addr_o), 32'(order[rd_idx]));
               dataRE_i = f_re(int'(data_i_addr_o));
               dataIM_i = f_im(int'(data_i_addr_o));
               rd_idx++;
               rd_cnt = 0;
            end
         end

         // stream side: optional backpressure on one sample
         fft_ready_i = 1'b1;
         if (out_idx == v.stall_at && st_cnt > 0 && st_cnt < v.stall_len) begin
            fft_ready_i = 1'b0;
            check("valid_held_in_stall", 32'(fft_valid_o), 1);
            check("re_held_in_stall", 32'(fft_re_o), 32'(hold_re));
            check("im_held_in_stall", 32'(fft_im_o), 32'(hold_im));
            check("rd_low_in_stall", 32'(data_rd_o), 0);
            st_cnt++;
         end else if (fft_valid_o) begin
            if (out_idx == v.stall_at && st_cnt == 0 && v.stall_len > 0) begin
               fft_ready_i = 1'b0;
               hold_re = fft_re_o;
               hold_im = fft_im_o;
               st_cnt  = 1;
            end else begin
               if (out_idx < NN) begin
                  check("re", 32'(fft_re_o), 32'(f_re(order[out_idx])));
                  check("im", 32'(fft_im_o), 32'(f_im(order[out_idx])));
                  check("last", 32'(fft_last_o), ((out_idx % N) == N - 1) ? 1 : 0);
               end
               out_idx++;
               st_cnt = 0;
            end
         end

         if (done_o) begin
            done_cyc   = cyc;
            fin        = 1'b1;
            check("busy_in_done", 32'(busy_o), 1);
            // start during the done cycle must be ignored
            start_i    = 1'b1;
            pass_col_i = ~v.pass_col;
         end
         tick();
         cyc++;
      end

      if (!fin) check("done_timeout", 0, 1);
      check("done_cycle", 32'(done_cyc), 32'(v.exp_done));
      check("samples_read", 32'(rd_idx), NN);
      check("samples_sent", 32'(out_idx), NN);
      check("done_one_cycle", 32'(done_o), 0);
      check("idle_busy", 32'(busy_o), 0);
      check("idle_rd", 32'(data_rd_o), 0);
      start_i = 1'b0;
      tick();
      check("start_in_done_ignored", 32'(data_rd_o), 0);
   endtask

   initial begin
      int done_seen;
`ifdef FFT2_DIN_CTRL_BITREV_EN
      exp_row = '{0, 2, 1, 3, 4, 6, 5, 7, 8, 10, 9, 11, 12, 14, 13, 15};
      exp_col = '{0, 8, 4, 12, 1, 9, 5, 13, 2, 10, 6, 14, 3, 11, 7, 15};
`else
      exp_row = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
      exp_col = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
`endif
      //           col   rd_at len stall_at len done
      tab[0] = '{1'b0, -1, 0, -1, 0, 33};
      tab[1] = '{1'b1, -1, 0, -1, 0, 33};
      tab[2] = '{1'b0, -1, 0,  2, 5, 38};
      tab[3] = '{1'b1,  5, 3, -1, 0, 36};
      tab[4] = '{1'b0,  0, 3, 15, 2, 38};

      rst         = 1'b1;
      start_i     = 1'b0;
      pass_col_i  = 1'b0;
      data_rd_i   = 1'b0;
      fft_ready_i = 1'b0;
      dataRE_i    = '0;
      dataIM_i    = '0;
      repeat (3) tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      for (int t = 0; t < 5; t++) begin
         run_pass(tab[t]);
         tick();
      end

      // reset in the middle of a pass
      pass_col_i  = 1'b0;
      start_i     = 1'b1;
      data_rd_i   = 1'b1;
      fft_ready_i = 1'b1;
      dataRE_i    = 16'h1234;
      dataIM_i    = 16'h5678;
      tick();
      start_i = 1'b0;
      repeat (13) tick();
      check("mid_pass_valid_before_rst", 32'(fft_valid_o), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_all_zero("midrst");
      done_seen = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (done_o) done_seen++;
      end
      check("no_done_after_rst", 32'(done_seen), 0);
      check("idle_after_rst", 32'(busy_o), 0);
      run_pass(tab[0]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
